// File: rtl/pipe_add_n.sv
// Pipelined WIDTH-bit adder: one SLICE-bit ripple segment per stage, global-stall valid/ready.
// Optional subtract mode enabled by defining PIPE_ADD_N_SUB_EN (adds the `sub` input).

module pipe_add_n_stage #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cy_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cy_o
);
  logic [SLICE:0]   part;
  logic [WIDTH-1:0] sum_nx;

  always_comb begin
    part   = {1'b0, x_i[K*SLICE +: SLICE]} + {1'b0, y_i[K*SLICE +: SLICE]}
           + {{SLICE{1'b0}}, cy_i};
    sum_nx = sum_i;
    sum_nx[K*SLICE +: SLICE] = part[SLICE-1:0];
  end

  // Data only moves with a valid beat, so the last stage holds its result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      sum_o <= '0;
      cy_o  <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
      if (vld_i) begin
        x_o   <= x_i;
        y_o   <= y_i;
        sum_o <= sum_nx;
        cy_o  <= part[SLICE];
      end
    end
  end
endmodule

module pipe_add_n #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cy_in,
`ifdef PIPE_ADD_N_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cy_out
);
  localparam int STAGES = (SLICE < 1) ? 1 : WIDTH / SLICE;

  if (SLICE < 1) begin : g_bad_slice
    $fatal(1, "pipe_add_n: SLICE must be >= 1");
  end else if (WIDTH % SLICE != 0) begin : g_bad_width
    $fatal(1, "pipe_add_n: WIDTH must be a multiple of SLICE");
  end

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] xp, yp, sp;
  logic [STAGES:0]            cp;
  logic                       stall;
  logic [WIDTH-1:0]           y_eff;
  logic                       c_eff;

`ifdef PIPE_ADD_N_SUB_EN
  // x - y as x + ~y + 1; the final carry is the no-borrow flag.
  assign y_eff = sub ? ~y : y;
  assign c_eff = sub | cy_in;
`else
  assign y_eff = y;
  assign c_eff = cy_in;
`endif

  assign stall       = out_valid && !out_ready;
  assign in_ready    = !stall;
  assign vld_pipe[0] = in_valid;
  assign xp[0]       = x;
  assign yp[0]       = y_eff;
  assign sp[0]       = '0;
  assign cp[0]       = c_eff;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_add_n_stage #(.WIDTH(WIDTH), .SLICE(SLICE), .K(k)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .vld_i (vld_pipe[k]),
      .x_i   (xp[k]),
      .y_i   (yp[k]),
      .sum_i (sp[k]),
      .cy_i  (cp[k]),
      .vld_o (vld_pipe[k+1]),
      .x_o   (xp[k+1]),
      .y_o   (yp[k+1]),
      .sum_o (sp[k+1]),
      .cy_o  (cp[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign s         = sp[STAGES];
  assign cy_out    = cp[STAGES];
endmodule
